// File: rtl/pc_unit_ras.sv
// Program counter with latched sequential/branch candidates, a circular return-address
// stack and a post-reset discard cycle. Define PC_INST_COUNT_EN to add the num_inst counter.
module pc_unit_ras #(
    parameter int                   WORD_SIZE    = 16,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
    parameter int                   RAS_DEPTH    = 4,
    parameter int                   CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           pc_source,
    input  logic [WORD_SIZE-1:0] next_target,
    input  logic                 pc_reg_write,
    input  logic                 pvs_write,
    input  logic                 ras_push,
    output logic [WORD_SIZE-1:0] inst_addr,
    output logic [WORD_SIZE-1:0] next_pc_seq,
    output logic [WORD_SIZE-1:0] next_pc_branch,
    output logic [WORD_SIZE-1:0] ras_top,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_overflow,
    output logic                 ras_underflow,
    output logic                 running
`ifdef PC_INST_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] num_inst
`endif
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_RETURN = 2'b11;

    logic [WORD_SIZE-1:0] inst_addr_reg, inst_addr_next;
    logic [WORD_SIZE-1:0] next_pc_seq_reg;
    logic [WORD_SIZE-1:0] next_pc_branch_reg;
    logic [PTR_W-1:0]     ras_ptr_reg, ras_ptr_next;
    logic [PTR_W:0]       ras_cnt_reg, ras_cnt_next;
    logic                 ras_overflow_reg, ras_underflow_reg;
    logic                 rest_reg;

    logic [WORD_SIZE-1:0] ras_mem [RAS_DEPTH];
    logic                 ras_wr_en;
    logic [PTR_W-1:0]     ras_wr_idx;
    logic                 ovf_set, unf_set;
    logic                 commit_en, latch_en;
    logic                 empty_w, full_w;
    logic [WORD_SIZE-1:0] top_w;

    assign commit_en = !rest_reg && pvs_write;
    assign latch_en  = !rest_reg && pc_reg_write && !pvs_write;
    assign empty_w   = (ras_cnt_reg == '0);
    assign full_w    = (ras_cnt_reg == DEPTH_CNT);
    assign top_w     = empty_w ? '0 : ras_mem[ras_ptr_reg];

    // ras_ptr_reg indexes the current top; a push lands one slot above it, which when
    // full is the oldest entry, so the stack overwrites circularly.
    always_comb begin
        inst_addr_next = inst_addr_reg;
        ras_ptr_next   = ras_ptr_reg;
        ras_cnt_next   = ras_cnt_reg;
        ras_wr_en      = 1'b0;
        ras_wr_idx     = ras_ptr_reg;
        ovf_set        = 1'b0;
        unf_set        = 1'b0;
        if (commit_en) begin
            case (pc_source)
                SRC_SEQ:    inst_addr_next = next_pc_seq_reg;
                SRC_BRANCH: inst_addr_next = next_pc_branch_reg;
                SRC_JUMP:   inst_addr_next = next_target;
                default: begin
                    if (empty_w) begin
                        inst_addr_next = next_pc_seq_reg;
                        unf_set        = 1'b1;
                    end else begin
                        inst_addr_next = top_w;
                    end
                end
            endcase
            if (pc_source == SRC_RETURN && !empty_w) begin
                if (ras_push) begin
                    // Return and call together: replace the top in place.
                    ras_wr_en  = 1'b1;
                    ras_wr_idx = ras_ptr_reg;
                end else begin
                    ras_ptr_next = ras_ptr_reg - 1'b1;
                    ras_cnt_next = ras_cnt_reg - 1'b1;
                end
            end else if (ras_push) begin
                ras_wr_en    = 1'b1;
                ras_wr_idx   = ras_ptr_reg + 1'b1;
                ras_ptr_next = ras_ptr_reg + 1'b1;
                if (full_w) begin
                    ovf_set = 1'b1;
                end else begin
                    ras_cnt_next = ras_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_addr_reg      <= RESET_VECTOR;
            next_pc_seq_reg    <= '0;
            next_pc_branch_reg <= '0;
            ras_ptr_reg        <= '0;
            ras_cnt_reg        <= '0;
            ras_overflow_reg   <= 1'b0;
            ras_underflow_reg  <= 1'b0;
            rest_reg           <= 1'b1;
        end else if (rest_reg) begin
            rest_reg <= 1'b0;
        end else begin
            inst_addr_reg <= inst_addr_next;
            ras_ptr_reg   <= ras_ptr_next;
            ras_cnt_reg   <= ras_cnt_next;
            if (ovf_set) ras_overflow_reg <= 1'b1;
            if (unf_set) ras_underflow_reg <= 1'b1;
            if (latch_en && pc_source == SRC_SEQ) next_pc_seq_reg <= next_target;
            if (latch_en && pc_source == SRC_BRANCH) next_pc_branch_reg <= next_target;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            logic [WORD_SIZE-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (ras_wr_en && ras_wr_idx == PTR_W'(gi)) begin
                    entry_reg <= next_pc_seq_reg;
                end
            end
            assign ras_mem[gi] = entry_reg;
        end
    endgenerate

`ifdef PC_INST_COUNT_EN
    logic [CNT_WIDTH-1:0] num_inst_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            num_inst_reg <= '0;
        end else if (commit_en) begin
            num_inst_reg <= num_inst_reg + 1'b1;
        end
    end
    assign num_inst = num_inst_reg;
`endif

    assign inst_addr      = inst_addr_reg;
    assign next_pc_seq    = next_pc_seq_reg;
    assign next_pc_branch = next_pc_branch_reg;
    assign ras_top        = top_w;
    assign ras_empty      = empty_w;
    assign ras_full       = full_w;
    assign ras_overflow   = ras_overflow_reg;
    assign ras_underflow  = ras_underflow_reg;
    assign running        = !rest_reg;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: reset/discard, latch/commit paths, RAS call/return,
// overflow/underflow, mid-instruction reset and (with PC_INST_COUNT_EN) the commit counter.
module tb_pc_unit_ras;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pc_source = 2'b00;
    logic [15:0] next_target = 16'h0000;
    logic        pc_reg_write = 1'b0;
    logic        pvs_write = 1'b0;
    logic        ras_push = 1'b0;
    logic [15:0] inst_addr, next_pc_seq, next_pc_branch, ras_top;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow, running;
`ifdef PC_INST_COUNT_EN
    logic [3:0]  num_inst;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    pc_unit_ras #(
        .WORD_SIZE(16), .RESET_VECTOR(16'h0000), .RAS_DEPTH(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .pc_source(pc_source), .next_target(next_target),
        .pc_reg_write(pc_reg_write), .pvs_write(pvs_write), .ras_push(ras_push),
        .inst_addr(inst_addr), .next_pc_seq(next_pc_seq), .next_pc_branch(next_pc_branch),
        .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .running(running)
`ifdef PC_INST_COUNT_EN
        , .num_inst(num_inst)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_latch(input logic [1:0] src, input logic [15:0] val);
        pc_source    = src;
        next_target  = val;
        pc_reg_write = 1'b1;
        tick();
        pc_reg_write = 1'b0;
        $display("latch  src=%0d val=%h -> seq=%h branch=%h", src, val, next_pc_seq, next_pc_branch);
    endtask

    task automatic do_commit(input logic [1:0] src, input logic [15:0] tgt, input logic push);
        pc_source   = src;
        next_target = tgt;
        ras_push    = push;
        pvs_write   = 1'b1;
        tick();
        pvs_write = 1'b0;
        ras_push  = 1'b0;
        $display("commit src=%0d tgt=%h push=%0b -> inst_addr=%h ras_top=%h", src, tgt, push, inst_addr, ras_top);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (inst_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_inst_addr got=%h exp=0000", inst_addr); end
        n_vec++; if (next_pc_seq !== 16'h0000 || next_pc_branch !== 16'h0000) begin n_fail++; $display("FAIL reset_cands got=%h/%h exp=0000/0000", next_pc_seq, next_pc_branch); end
        n_vec++; if ({ras_empty, ras_full, ras_top} !== {1'b1, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL reset_ras got e=%b f=%b top=%h exp e=1 f=0 top=0000", ras_empty, ras_full, ras_top); end
        n_vec++; if ({ras_overflow, ras_underflow, running} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {ras_overflow, ras_underflow, running}); end
`ifdef PC_INST_COUNT_EN
        n_vec++; if (num_inst !== 4'd0) begin n_fail++; $display("FAIL reset_num_inst got=%0d exp=0", num_inst); end
`endif
        // Release with a commit pending: the discard edge must swallow it.
        reset       = 1'b0;
        pc_source   = 2'b10;
        next_target = 16'h5555;
        pvs_write   = 1'b1;
        pc_reg_write = 1'b1;
        #1;
        n_vec++; if (running !== 1'b0) begin n_fail++; $display("FAIL discard_running_pre got=%b exp=0", running); end
        tick();
        pvs_write    = 1'b0;
        pc_reg_write = 1'b0;
        $display("discard edge -> inst_addr=%h running=%b", inst_addr, running);
        n_vec++; if (running !== 1'b1) begin n_fail++; $display("FAIL discard_running_post got=%b exp=1", running); end
        n_vec++; if (inst_addr !== 16'h0000) begin n_fail++; $display("FAIL discard_inst_addr got=%h exp=0000", inst_addr); end
`ifdef PC_INST_COUNT_EN
        n_vec++; if (num_inst !== 4'd0) begin n_fail++; $display("FAIL discard_num_inst got=%0d exp=0", num_inst); end
`endif
    endtask

    task automatic test_sequential();
        do_latch(2'b00, 16'h0001);
        n_vec++; if (next_pc_seq !== 16'h0001) begin n_fail++; $display("FAIL seq_latch got=%h exp=0001", next_pc_seq); end
        do_commit(2'b00, 16'h0000, 1'b0);
        n_vec++; if (inst_addr !== 16'h0001) begin n_fail++; $display("FAIL seq_commit got=%h exp=0001", inst_addr); end
        do_commit(2'b00, 16'h0000, 1'b0);
        n_vec++; if (inst_addr !== 16'h0001) begin n_fail++; $display("FAIL seq_recommit got=%h exp=0001", inst_addr); end
        // pc_reg_write must be ignored while committing
        pc_reg_write = 1'b1;
        do_commit(2'b00, 16'h7777, 1'b0);
        pc_reg_write = 1'b0;
        n_vec++; if (next_pc_seq !== 16'h0001 || inst_addr !== 16'h0001) begin n_fail++; $display("FAIL latch_during_commit got seq=%h pc=%h exp 0001/0001", next_pc_seq, inst_addr); end
    endtask

    task automatic test_branch_jump();
        do_latch(2'b01, 16'h0040);
        n_vec++; if (next_pc_branch !== 16'h0040 || next_pc_seq !== 16'h0001) begin n_fail++; $display("FAIL branch_latch got br=%h seq=%h exp 0040/0001", next_pc_branch, next_pc_seq); end
        do_latch(2'b10, 16'h0999);
        n_vec++; if (next_pc_branch !== 16'h0040 || next_pc_seq !== 16'h0001) begin n_fail++; $display("FAIL latch_src10 got br=%h seq=%h exp 0040/0001", next_pc_branch, next_pc_seq); end
        do_commit(2'b01, 16'h0000, 1'b0);
        n_vec++; if (inst_addr !== 16'h0040) begin n_fail++; $display("FAIL branch_commit got=%h exp=0040", inst_addr); end
        do_commit(2'b10, 16'h1234, 1'b0);
        n_vec++; if (inst_addr !== 16'h1234) begin n_fail++; $display("FAIL jump_commit got=%h exp=1234", inst_addr); end
    endtask

    task automatic test_call_return();
        do_latch(2'b00, 16'h0011);
        do_commit(2'b10, 16'h0200, 1'b1);
        n_vec++; if (inst_addr !== 16'h0200 || ras_top !== 16'h0011 || ras_empty !== 1'b0) begin n_fail++; $display("FAIL call got pc=%h top=%h e=%b exp 0200/0011/0", inst_addr, ras_top, ras_empty); end
        do_commit(2'b11, 16'h0000, 1'b0);
        n_vec++; if (inst_addr !== 16'h0011 || ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL return got pc=%h e=%b u=%b exp 0011/1/0", inst_addr, ras_empty, ras_underflow); end
        ras_push = 1'b1;
        tick();
        ras_push = 1'b0;
        n_vec++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL push_no_commit got e=%b exp=1", ras_empty); end
    endtask

    task automatic test_overflow_underflow();
        logic [15:0] vals [5];
        logic [15:0] pops [4];
        vals = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E};
        pops = '{16'h000E, 16'h000D, 16'h000C, 16'h000B};
        for (int i = 0; i < 5; i++) begin
            do_latch(2'b00, vals[i]);
            do_commit(2'b10, 16'h0100, 1'b1);
            if (i == 3) begin
                n_vec++; if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin n_fail++; $display("FAIL ras_fill got f=%b o=%b exp 1/0", ras_full, ras_overflow); end
            end
        end
        n_vec++; if (ras_overflow !== 1'b1 || ras_full !== 1'b1 || ras_top !== 16'h000E) begin n_fail++; $display("FAIL overflow got o=%b f=%b top=%h exp 1/1/000e", ras_overflow, ras_full, ras_top); end
        for (int i = 0; i < 4; i++) begin
            do_commit(2'b11, 16'h0000, 1'b0);
            n_vec++; if (inst_addr !== pops[i]) begin n_fail++; $display("FAIL pop%0d got=%h exp=%h", i, inst_addr, pops[i]); end
        end
        n_vec++; if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL drained got e=%b u=%b exp 1/0", ras_empty, ras_underflow); end
        do_latch(2'b00, 16'h0077);
        do_commit(2'b11, 16'h0000, 1'b0);
        n_vec++; if (inst_addr !== 16'h0077 || ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL underflow got pc=%h u=%b e=%b exp 0077/1/1", inst_addr, ras_underflow, ras_empty); end
        n_vec++; if (ras_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got=%b exp=1", ras_overflow); end
    endtask

    task automatic test_back_to_back();
        do_latch(2'b00, 16'h0021);
        do_commit(2'b10, 16'h0300, 1'b1);
        do_latch(2'b00, 16'h0022);
        do_commit(2'b11, 16'h0000, 1'b1);
        n_vec++; if (inst_addr !== 16'h0021 || ras_top !== 16'h0022 || ras_empty !== 1'b0) begin n_fail++; $display("FAIL push_return got pc=%h top=%h e=%b exp 0021/0022/0", inst_addr, ras_top, ras_empty); end
        do_commit(2'b11, 16'h0000, 1'b0);
        n_vec++; if (inst_addr !== 16'h0022 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL push_return_pop got pc=%h e=%b exp 0022/1", inst_addr, ras_empty); end
        // push+return on an empty stack: push happens, PC falls back to next_pc_seq
        do_commit(2'b11, 16'h0000, 1'b1);
        n_vec++; if (inst_addr !== 16'h0022 || ras_top !== 16'h0022 || ras_empty !== 1'b0) begin n_fail++; $display("FAIL push_return_empty got pc=%h top=%h e=%b exp 0022/0022/0", inst_addr, ras_top, ras_empty); end
    endtask

    task automatic test_reset_mid();
        do_latch(2'b01, 16'h0044);
        do_commit(2'b10, 16'h0500, 1'b1);
        reset = 1'b1;
        tick();
        n_vec++; if (inst_addr !== 16'h0000 || next_pc_seq !== 16'h0000 || next_pc_branch !== 16'h0000) begin n_fail++; $display("FAIL midreset_regs got %h/%h/%h exp 0000/0000/0000", inst_addr, next_pc_seq, next_pc_branch); end
        n_vec++; if ({ras_empty, ras_top, ras_overflow, ras_underflow, running} !== {1'b1, 16'h0000, 3'b000}) begin n_fail++; $display("FAIL midreset_ras got e=%b top=%h o=%b u=%b r=%b exp 1/0000/0/0/0", ras_empty, ras_top, ras_overflow, ras_underflow, running); end
        reset = 1'b0;
        tick();
    endtask

`ifdef PC_INST_COUNT_EN
    task automatic test_inst_count();
        for (int i = 0; i < 5; i++) do_commit(2'b00, 16'h0000, 1'b0);
        n_vec++; if (num_inst !== 4'd5) begin n_fail++; $display("FAIL count5 got=%0d exp=5", num_inst); end
        for (int i = 0; i < 12; i++) do_commit(2'b00, 16'h0000, 1'b0);
        n_vec++; if (num_inst !== 4'd1) begin n_fail++; $display("FAIL count17_wrap got=%0d exp=1", num_inst); end
        reset = 1'b1;
        tick();
        n_vec++; if (num_inst !== 4'd0) begin n_fail++; $display("FAIL count_reset got=%0d exp=0", num_inst); end
        reset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch_jump();
        test_call_return();
        test_overflow_underflow();
        test_back_to_back();
        test_reset_mid();
`ifdef PC_INST_COUNT_EN
        test_inst_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
